// File: rtl/rls_state_update.sv
// RLS state update: x = x0 + k*(b - a'*x0) in signed fixed point.
// The dot product and the update each sweep the vectors LANES elements
// per cycle; a product register between multiply and accumulate adds one
// fill cycle to the dot phase.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// DOT    | multiply/accumulate a'*x0, one lane group per cycle
// SUB    | e = b - a'*x0, saturated into err
// UPDATE | x[i] = sat(x0[i] + k[i]*e), one lane group per cycle
// DONE   | result valid, held until out_ready
module rls_state_update #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 16,
    parameter int LANES = 4,
    parameter int FRAC  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*SIZE-1:0]   x0,
    input  logic [WIDTH*SIZE-1:0]   k,
    input  logic [WIDTH*SIZE-1:0]   a,
    input  logic [WIDTH-1:0]        b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*SIZE-1:0]   x,
    output logic [WIDTH-1:0]        err,
    output logic                    busy
);

    localparam int P   = SIZE / LANES;
    localparam int PW  = 2 * WIDTH;
    localparam int AW  = 2 * WIDTH + $clog2(SIZE);
    localparam int DW  = AW + 1;
    localparam int CW  = $clog2(P + 1);
    localparam int GW  = (P > 1) ? $clog2(P) : 1;
    localparam int IXW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, DOT, SUB, UPDATE, DONE} state_t;

    state_t                   state;
    logic signed [WIDTH-1:0]  x0_r  [SIZE];
    logic signed [WIDTH-1:0]  k_r   [SIZE];
    logic signed [WIDTH-1:0]  a_r   [SIZE];
    logic signed [WIDTH-1:0]  x_r   [SIZE];
    logic signed [WIDTH-1:0]  b_r;
    logic signed [WIDTH-1:0]  err_r;
    logic signed [AW-1:0]     acc;
    logic signed [PW-1:0]     prod  [LANES];
    logic                     prod_vld;
    logic [CW-1:0]            cnt;
    logic [GW-1:0]            grp;
    logic [GW-1:0]            next_grp;

    logic [IXW-1:0]           idx     [LANES];
    logic signed [AW-1:0]     lane_sum;
    logic signed [DW-1:0]     diff;
    logic signed [WIDTH-1:0]  err_sat;
    logic signed [PW-1:0]     kp      [LANES];
    logic signed [PW-1:0]     kp_sh   [LANES];
    logic signed [PW:0]       upd_sum [LANES];
    logic signed [WIDTH-1:0]  upd     [LANES];

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign err       = err_r;
    assign next_grp  = (grp == GW'(P - 1)) ? '0 : grp + 1'b1;

    for (genvar i = 0; i < SIZE; i++) begin : g_xout
        assign x[WIDTH*i +: WIDTH] = x_r[i];
    end

    // Lane datapath: element indices, accumulate sum, error and saturated update values
    always_comb begin
        lane_sum = '0;
        diff     = DW'(b_r) - DW'(acc >>> FRAC);
        if (diff[DW-1:WIDTH-1] == {(DW-WIDTH+1){diff[DW-1]}})
            err_sat = diff[WIDTH-1:0];
        else
            err_sat = diff[DW-1] ? SAT_MIN : SAT_MAX;
        for (int l = 0; l < LANES; l++) begin
            idx[l]     = IXW'(int'(grp) * LANES + l);
            lane_sum   = lane_sum + AW'(prod[l]);
            kp[l]      = PW'(k_r[idx[l]]) * PW'(err_r);
            kp_sh[l]   = kp[l] >>> FRAC;
            upd_sum[l] = (PW+1)'(x0_r[idx[l]]) + (PW+1)'(kp_sh[l]);
            if (upd_sum[l][PW:WIDTH-1] == {(PW-WIDTH+2){upd_sum[l][PW]}})
                upd[l] = upd_sum[l][WIDTH-1:0];
            else
                upd[l] = upd_sum[l][PW] ? SAT_MIN : SAT_MAX;
        end
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            b_r      <= '0;
            err_r    <= '0;
            acc      <= '0;
            prod_vld <= 1'b0;
            cnt      <= '0;
            grp      <= '0;
            for (int i = 0; i < SIZE; i++) begin
                x0_r[i] <= '0;
                k_r[i]  <= '0;
                a_r[i]  <= '0;
                x_r[i]  <= '0;
            end
            for (int l = 0; l < LANES; l++) prod[l] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < SIZE; i++) begin
                            x0_r[i] <= x0[WIDTH*i +: WIDTH];
                            k_r[i]  <= k[WIDTH*i +: WIDTH];
                            a_r[i]  <= a[WIDTH*i +: WIDTH];
                        end
                        b_r      <= b;
                        acc      <= '0;
                        prod_vld <= 1'b0;
                        cnt      <= CW'(P);
                        grp      <= '0;
                        state    <= DOT;
                    end
                end
                DOT: begin
                    if (prod_vld) acc <= acc + lane_sum;
                    if (cnt != '0) begin
                        for (int l = 0; l < LANES; l++)
                            prod[l] <= PW'(a_r[idx[l]]) * PW'(x0_r[idx[l]]);
                        prod_vld <= 1'b1;
                        cnt      <= cnt - 1'b1;
                        grp      <= next_grp;
                    end else begin
                        prod_vld <= 1'b0;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    err_r <= err_sat;
                    cnt   <= CW'(P);
                    grp   <= '0;
                    state <= UPDATE;
                end
                UPDATE: begin
                    for (int l = 0; l < LANES; l++) x_r[idx[l]] <= upd[l];
                    cnt <= cnt - 1'b1;
                    grp <= next_grp;
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rls_state_update.sv
// Scoreboard bench for rls_state_update: the driver queues expected results,
// a negedge monitor checks latency and data on every output handshake.
module tb_rls_state_update;

    localparam int W    = 32;
    localparam int S    = 16;
    localparam int L    = 4;
    localparam int P    = S / L;
    localparam int LAT  = 2 * P + 2;
    localparam int LAT1 = 2 * S + 2;

    typedef logic [W*S-1:0] v_t;
    typedef struct { v_t xv; logic [W-1:0] ev; } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b1;
    logic          in_valid1 = 1'b0, out_ready1 = 1'b1;
    v_t            x0 = '0, k = '0, a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready, out_valid, busy, in_ready1, out_valid1, busy1;
    v_t            x, x1;
    logic [W-1:0]  err, err1;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   lat_n = 0;
    bit   lat_run = 1'b0;
    bit   valid_seen = 1'b0;

    always #5 clk = ~clk;

    rls_state_update #(.WIDTH(W), .SIZE(S), .LANES(L), .FRAC(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .k(k), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .err(err), .busy(busy));

    rls_state_update #(.WIDTH(W), .SIZE(S), .LANES(1), .FRAC(16)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .x0(x0), .k(k), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready1),
        .x(x1), .err(err1), .busy(busy1));

    task automatic chk(input string name, input v_t act, input v_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Accept edge starts the latency count
    always @(posedge clk) begin
        if (!reset && in_valid && in_ready) begin
            lat_run = 1'b1;
            lat_n   = -1;
        end
    end

    // Monitor: latency on first valid cycle, data on handshake
    always @(negedge clk) begin
        if (reset) begin
            lat_run    = 1'b0;
            valid_seen = 1'b0;
        end else begin
            if (lat_run) lat_n++;
            if (out_valid && !valid_seen) begin
                valid_seen = 1'b1;
                lat_run    = 1'b0;
                chk("latency", v_t'(lat_n), v_t'(LAT));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output x=%0h err=%0h with empty queue", x, err);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("x", x, e.xv);
                    chk("err", v_t'(err), v_t'(e.ev));
                end
                valid_seen = 1'b0;
            end
        end
    end

    task automatic send(input v_t vx0, input v_t vk, input v_t va, input logic [W-1:0] vb,
                        input bit push, input v_t ex, input logic [W-1:0] ee);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready actual=0 required=1");
        end
        x0 = vx0; k = vk; a = va; b = vb;
        in_valid = 1'b1;
        if (push) q.push_back('{ex, ee});
        @(posedge clk); #1;
        in_valid = 1'b0;
        // scramble operands after acceptance; the result must not depend on them
        x0 = {S{$urandom()}};
        k  = {S{$urandom()}};
        a  = {S{$urandom()}};
        b  = $urandom();
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout busy actual=1 required=0", name);
        end
    endtask

    localparam v_t ONE_V  = {S{32'h00010000}};
    localparam v_t HALF_V = {S{32'h00008000}};
    localparam v_t XA     = {S{32'h00030000}};
    localparam v_t X0B    = {S{32'h7FFF0000}};
    localparam v_t XB     = {S{32'h7FFFFFFF}};
    localparam v_t AC     = {{(S-1){32'h0}}, 32'h00010000};
    localparam v_t X0C    = {{(S-1){32'h0}}, 32'h00020000};
    localparam v_t XC     = {{(S-1){32'hFFFE0000}}, 32'h0};

    initial begin
        int n;
        #3;
        chk("rst_x", x, '0);
        chk("rst_err", v_t'(err), '0);
        chk("rst_out_valid", v_t'(out_valid), '0);
        chk("rst_busy", v_t'(busy), '0);
        chk("rst_in_ready", v_t'(in_ready), v_t'(1'b1));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // nominal update
        send(ONE_V, HALF_V, ONE_V, 32'h00140000, 1'b1, XA, 32'h00040000);
        wait_done("a");
        chk("valid_pulse", v_t'(out_valid), '0);

        // positive saturation
        send(X0B, ONE_V, '0, 32'h00640000, 1'b1, XB, 32'h00640000);
        wait_done("b");

        // single nonzero element, negative error
        send(X0C, ONE_V, AC, 32'h0, 1'b1, XC, 32'hFFFE0000);
        wait_done("c");

        // back-pressure in DONE with ignored in_valid pulses
        out_ready = 1'b0;
        send(X0B, ONE_V, '0, 32'h00640000, 1'b1, XB, 32'h00640000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_reach_done", v_t'(out_valid), v_t'(1'b1));
        repeat (5) begin
            in_valid = 1'b1;
            x0 = {S{$urandom()}};
            @(negedge clk);
            chk("stall_out_valid", v_t'(out_valid), v_t'(1'b1));
            chk("stall_in_ready", v_t'(in_ready), '0);
            chk("stall_x", x, XB);
            chk("stall_err", v_t'(err), v_t'(32'h00640000));
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", v_t'(in_ready), v_t'(1'b1));
        chk("release_out_valid", v_t'(out_valid), '0);
        chk("release_busy", v_t'(busy), '0);

        // reset in the middle of DOT
        send(ONE_V, HALF_V, ONE_V, 32'h00140000, 1'b0, '0, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_x", x, '0);
        chk("abort_err", v_t'(err), '0);
        chk("abort_out_valid", v_t'(out_valid), '0);
        chk("abort_busy", v_t'(busy), '0);
        chk("abort_in_ready", v_t'(in_ready), v_t'(1'b1));
        @(negedge clk);
        reset = 1'b0;
        #1;
        send(ONE_V, HALF_V, ONE_V, 32'h00140000, 1'b1, XA, 32'h00040000);
        wait_done("after_abort");

        // single-lane instance
        x0 = ONE_V; k = HALF_V; a = ONE_V; b = 32'h00140000;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lanes1_latency", v_t'(n), v_t'(LAT1));
        chk("lanes1_x", x1, XA);
        chk("lanes1_err", v_t'(err1), v_t'(32'h00040000));
        @(posedge clk); #1;
        chk("lanes1_valid_pulse", v_t'(out_valid1), '0);

        chk("queue_empty", v_t'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
